// File: rtl/accumulator_top_core.sv
// Sums NUM_WORDS consecutive 32-bit load words across LANES partial-sum lanes, wrapping modulo 2^32.
// Latency: result/done valid after edge NUM_WORDS+1 following reset release; then held until reset.
// No backpressure: one word is consumed every edge while collecting; load is ignored once reducing or done.
module accumulator_top_core #(
  parameter int NUM_WORDS = 1024,
  parameter int LANES     = 4
) (
  input  logic        bus_clk,
  input  logic        reset,
  input  logic [31:0] load,
  output logic [31:0] result,
  output logic        done
);

  localparam int            CW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(NUM_WORDS - 1);
  // LANES is a power of two dividing NUM_WORDS, so the low counter bits pick the lane
  localparam logic [CW-1:0] LANE_MASK = CW'(LANES - 1);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_REDUCE  = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          collect_en;
  logic          reduce_en;
  logic [CW-1:0] word_cnt;
  logic [31:0]   lane_sum [LANES];
  logic [31:0]   lane_total;

  // State register; reset always restarts a fresh collection run
  always_ff @(posedge bus_clk or negedge reset) begin
    if (!reset) begin
      state <= ST_COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: leave COLLECT on the last word, spend one cycle reducing, then park in DONE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_COLLECT: if (word_cnt == LAST_WORD) state_nxt = ST_REDUCE;
      ST_REDUCE:  state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_DONE;
      default:    state_nxt = ST_COLLECT;
    endcase
  end

  // Per-state enables for the datapath
  always_comb begin
    collect_en = 1'b0;
    reduce_en  = 1'b0;
    case (state)
      ST_COLLECT: collect_en = 1'b1;
      ST_REDUCE:  reduce_en  = 1'b1;
      default:    ;
    endcase
  end

  // Word counter, advances once per sampled word
  always_ff @(posedge bus_clk or negedge reset) begin
    if (!reset) begin
      word_cnt <= '0;
    end else if (collect_en) begin
      word_cnt <= word_cnt + 1'b1;
    end
  end

  // Lane partial sums: word k lands in lane k mod LANES
  always_ff @(posedge bus_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LANES; i++) begin
        lane_sum[i] <= '0;
      end
    end else if (collect_en) begin
      for (int i = 0; i < LANES; i++) begin
        if ((word_cnt & LANE_MASK) == CW'(i)) begin
          lane_sum[i] <= lane_sum[i] + load;
        end
      end
    end
  end

  // Final reduction across lanes, modulo 2^32
  always_comb begin
    lane_total = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_total = lane_total + lane_sum[i];
    end
  end

  // Result and done are only written in the reduce cycle, so partial sums never reach the port
  always_ff @(posedge bus_clk or negedge reset) begin
    if (!reset) begin
      result <= '0;
      done   <= 1'b0;
    end else if (reduce_en) begin
      result <= lane_total;
      done   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_accumulator_top_core.sv
// Bench for accumulator_top_core: directed runs from the requirement list plus randomized runs
// checked against a plain-arithmetic running sum; includes reset mid-collect, mid-reduce and in done.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_accumulator_top_core;

  localparam int NW = 1024;

  logic        bus_clk;
  logic        reset;
  logic [31:0] load;
  logic [31:0] result;
  logic        done;

  int tests;
  int fails;

  accumulator_top_core #(.NUM_WORDS(NW), .LANES(4)) dut (
    .bus_clk (bus_clk),
    .reset   (reset),
    .load    (load),
    .result  (result),
    .done    (done)
  );

  initial bus_clk = 1'b0;
  always #5 bus_clk = ~bus_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Assert reset away from an edge, confirm the asynchronous clear, release on a falling edge
  task automatic pulse_reset(input string tag);
    @(negedge bus_clk);
    #2;
    reset = 1'b0;
    #1;
    check({tag, "_rst_result"}, result, 32'd0);
    check({tag, "_rst_done"}, {31'd0, done}, 32'd0);
    @(negedge bus_clk);
    reset = 1'b1;
  endtask

  // Feed a full run. mode 0: constant c, 1: word index, 2: random.
  // Reference: expected sum is the plain 32-bit wrapped total of every word fed.
  task automatic run_words(input string tag, input int mode, input logic [31:0] c,
                           input bit use_spec, input logic [31:0] spec_exp,
                           input bit reset_in_reduce);
    logic [31:0] model;
    logic [31:0] w;
    bit          early;
    model = 32'd0;
    early = 1'b0;
    for (int k = 0; k < NW; k++) begin
      case (mode)
        0:       w = c;
        1:       w = 32'(k);
        default: w = $urandom;
      endcase
      load  = w;
      model = model + w;
      @(posedge bus_clk);
      @(negedge bus_clk);
      if (done !== 1'b0 || result !== 32'd0) early = 1'b1;
    end
    check({tag, "_quiet_before_done"}, {31'd0, early}, 32'd0);
    load = $urandom;
    if (reset_in_reduce) begin
      #2;
      reset = 1'b0;
      #1;
      check({tag, "_reduce_rst_result"}, result, 32'd0);
      @(negedge bus_clk);
      check({tag, "_reduce_rst_done"}, {31'd0, done}, 32'd0);
      reset = 1'b1;
    end else begin
      @(posedge bus_clk);
      @(negedge bus_clk);
      check({tag, "_done"}, {31'd0, done}, 32'd1);
      check({tag, "_result"}, result, use_spec ? spec_exp : model);
    end
  endtask

  initial begin
    logic [31:0] held_res;
    bit          moved;
    tests = 0;
    fails = 0;
    reset = 1'b0;
    load  = 32'd0;
    repeat (3) @(negedge bus_clk);
    check("reset_result", result, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    reset = 1'b1;

    // All ones: result equals the word count
    run_words("ones", 0, 32'd1, 1'b1, 32'd1024, 1'b0);

    // Idle in done with a loud pattern on load; nothing may change
    held_res = result;
    moved    = 1'b0;
    load     = 32'hDEADBEEF;
    repeat (100) begin
      @(posedge bus_clk);
      @(negedge bus_clk);
      if (result !== held_res || done !== 1'b1) moved = 1'b1;
    end
    check("done_hold_moved", {31'd0, moved}, 32'd0);
    check("done_hold_result", result, 32'd1024);

    pulse_reset("from_done");
    run_words("index", 1, 32'd0, 1'b1, 32'h0007FE00, 1'b0);

    pulse_reset("p2");
    run_words("ffff", 0, 32'h0000FFFF, 1'b1, 32'h03FFFC00, 1'b0);

    pulse_reset("p3");
    run_words("wrap", 0, 32'hFFFFFFFF, 1'b1, 32'hFFFFFC00, 1'b0);

    // Partial run of 7s, reset mid-collect, then a clean run of 2s
    pulse_reset("p4");
    moved = 1'b0;
    load  = 32'd7;
    repeat (500) begin
      @(posedge bus_clk);
      @(negedge bus_clk);
      if (result !== 32'd0 || done !== 1'b0) moved = 1'b1;
    end
    check("partial_quiet", {31'd0, moved}, 32'd0);
    pulse_reset("mid_collect");
    run_words("twos", 0, 32'd2, 1'b1, 32'd2048, 1'b0);

    // Randomized runs against the reference sum
    pulse_reset("p5");
    run_words("rand_a", 2, 32'd0, 1'b0, 32'd0, 1'b0);
    pulse_reset("p6");
    run_words("rand_b", 2, 32'd0, 1'b0, 32'd0, 1'b0);

    // Reset during the reduce cycle discards everything; the next run stands alone
    pulse_reset("p7");
    run_words("rand_abort", 2, 32'd0, 1'b0, 32'd0, 1'b1);
    run_words("rand_c", 2, 32'd0, 1'b0, 32'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/accumulator_top_core.md
ACCUMULATOR_TOP_CORE -- requirements
Module: accumulator_top

Interface
REQ-001 The block SHALL have parameter NUM_WORDS, default 1024, number of words summed per run.
REQ-002 The block SHALL have parameter LANES, default 4, number of parallel partial-sum lanes; power of two; divides NUM_WORDS.
REQ-003 The block SHALL have the following ports:
- bus_clk  input  1  sole clock, all state on rising edge.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- load  input  32  data word, sampled every rising edge while collecting.
- result  output  32  final sum; valid when done=1.
- done  output  1  high once result is valid; held until reset.
REQ-004 The block SHALL be single-clock; no proc_clk or other clock input exists.

Function
REQ-005 The block SHALL implement three states: COLLECT, REDUCE, DONE; COLLECT is entered on reset.
REQ-006 In COLLECT the block SHALL sample load on each rising edge, beginning with the first rising edge after reset deasserts (reset=1).
REQ-007 Word index k (0..NUM_WORDS-1) SHALL be added into lane partial sum p[k mod LANES]; each lane is a 32-bit register, addition modulo 2^32.
REQ-008 A 10-bit (clog2(NUM_WORDS)) word counter SHALL increment per sampled word; when word NUM_WORDS-1 is sampled, next state is REDUCE.
REQ-009 In REDUCE (one cycle) the block SHALL compute the sum of all LANES partial sums, modulo 2^32, register it into result, and assert done; next state DONE.
REQ-010 Latency: result and done SHALL be valid immediately after the rising edge following the edge on which word NUM_WORDS-1 was sampled (edge NUM_WORDS+1 after reset release).
REQ-011 In DONE, result and done SHALL hold constant; load SHALL be ignored; only reset leaves DONE.
REQ-012 result SHALL read 0 and done SHALL read 0 in COLLECT and REDUCE; result never presents X or partial sums.
REQ-013 Overflow SHALL wrap silently (modulo 2^32); no overflow flag exists.
REQ-014 Load values are not range-checked; all 32 bits participate in the sum.

Reset
REQ-015 reset=0 SHALL asynchronously clear all lane sums, the counter, result (0) and done (0), and force state COLLECT.
REQ-016 Reset asserted mid-COLLECT or mid-REDUCE SHALL discard all prior words; a new run of NUM_WORDS words starts at the first rising edge after release.
REQ-017 Reset asserted in DONE SHALL clear result and done and start a new run.

Verification
REQ-018 Reset, then load=1 for 1024 edges -> done=1 and result=1024 after edge 1025; result=0 before.
REQ-019 Load = word index (0..1023) -> result=523776 (0x0007FE00).
REQ-020 Load = 0x0000FFFF for all words -> result=67107840 (0x03FFFC00).
REQ-021 Load = 0xFFFFFFFF for all words -> result=0xFFFFFC00 (wrap).
REQ-022 Load=7 for 500 words, reset pulsed low, then load=2 for 1024 words -> result=2048, done asserted exactly 1025 edges after release.
REQ-023 After done, drive load=0xDEADBEEF for 100 edges -> result and done unchanged.
